// File: rtl/end_screen_sequencer.sv
// End-of-game sequencer: latches lose/win, fades the game image, shows a centred bitmap,
// and pulses game_reset on start. Define END_SCREEN_FADE_EN to build the fade stage and scaler.
module end_screen_sequencer #(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int IMG_X0      = 160,
  parameter int IMG_Y0      = 120,
  parameter int FADE_STEP   = 2,
  parameter int HOLD_FRAMES = 60
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        game_over,
  input  logic        game_won,
  input  logic        start,
  input  logic [3:0]  game_r,
  input  logic [3:0]  game_g,
  input  logic [3:0]  game_b,
  input  logic [3:0]  ov_r,
  input  logic [3:0]  ov_g,
  input  logic [3:0]  ov_b,
  output logic [16:0] img_addr,
  output logic        img_sel,
  output logic        end_screen,
  output logic        game_reset,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [1:0]  dbg_state
);

  if (FADE_STEP < 1 || HOLD_FRAMES < 1) begin : g_param_check
    $error("end_screen_sequencer: FADE_STEP and HOLD_FRAMES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_FADE = 2'd1,
    S_SHOW = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam int HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_FRAMES - 1);

  localparam logic [10:0] X_LO = 11'(IMG_X0);
  localparam logic [10:0] X_HI = 11'(IMG_X0 + IMG_W);
  localparam logic [10:0] Y_LO = 11'(IMG_Y0);
  localparam logic [10:0] Y_HI = 11'(IMG_Y0 + IMG_H);

  state_t          state_q, state_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic            pend_lose_q, pend_lose_d;
  logic            pend_win_q, pend_win_d;
  logic            img_sel_q, img_sel_d;
  logic            game_reset_q, game_reset_d;
  logic            in_win_q;
  logic [11:0]     rgb_q, rgb_d;

  logic            frame_tick;
  logic            in_win;
  logic [10:0]     draw_x_w, draw_y_w;
  logic [9:0]      rel_x, rel_y;

`ifdef END_SCREEN_FADE_EN
  localparam int FCW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam logic [FCW-1:0] FADE_LAST = FCW'(FADE_STEP - 1);

  logic [4:0]      level_q, level_d;
  logic [FCW-1:0]  fade_cnt_q, fade_cnt_d;

  // 9-bit product keeps level 16 exact: (c*16)>>4 == c.
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lv);
    logic [8:0] p;
    p = 9'(c) * 9'(lv);
    return p[7:4];
  endfunction
`endif

  assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'd0);

  assign draw_x_w = {1'b0, DrawX};
  assign draw_y_w = {1'b0, DrawY};
  assign in_win   = (draw_x_w >= X_LO) && (draw_x_w < X_HI) &&
                    (draw_y_w >= Y_LO) && (draw_y_w < Y_HI);
  assign rel_x    = DrawX - X_LO[9:0];
  assign rel_y    = DrawY - Y_LO[9:0];
  assign img_addr = in_win ? (17'(rel_x) + 17'(rel_y) * 17'(IMG_W)) : 17'd0;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    pend_lose_d  = pend_lose_q;
    pend_win_d   = pend_win_q;
    img_sel_d    = img_sel_q;
    game_reset_d = 1'b0;
`ifdef END_SCREEN_FADE_EN
    level_d      = level_q;
    fade_cnt_d   = fade_cnt_q;
`endif
    case (state_q)
      S_PLAY: begin
        if (frame_tick && (pend_lose_q || pend_win_q)) begin
          img_sel_d   = pend_win_q & ~pend_lose_q;
          pend_lose_d = 1'b0;
          pend_win_d  = 1'b0;
          hold_cnt_d  = '0;
`ifdef END_SCREEN_FADE_EN
          // Preloading the step counter makes the first dimming land on the next tick.
          state_d     = S_FADE;
          level_d     = 5'd16;
          fade_cnt_d  = FADE_LAST;
`else
          state_d     = S_SHOW;
`endif
        end else begin
          pend_lose_d = pend_lose_q | game_over;
          pend_win_d  = pend_win_q | game_won;
        end
      end
`ifdef END_SCREEN_FADE_EN
      S_FADE: begin
        if (frame_tick) begin
          if (level_q == 5'd0) begin
            state_d    = S_SHOW;
            hold_cnt_d = '0;
          end else if (fade_cnt_q == FADE_LAST) begin
            level_d    = level_q - 5'd1;
            fade_cnt_d = '0;
          end else begin
            fade_cnt_d = fade_cnt_q + FCW'(1);
          end
        end
      end
`endif
      S_SHOW: begin
        if (frame_tick) begin
          if (hold_cnt_q == HOLD_LAST) state_d = S_HOLD;
          else                         hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      S_HOLD: begin
        if (start) begin
          state_d      = S_PLAY;
          game_reset_d = 1'b1;
          hold_cnt_d   = '0;
`ifdef END_SCREEN_FADE_EN
          level_d      = 5'd16;
`endif
        end
      end
      default: state_d = S_PLAY;
    endcase
  end

  // Overlay colour arrives one cycle after its address, so it pairs with the delayed in_win.
  always_comb begin
    rgb_d = 12'h000;
    if (blank) begin
      case (state_q)
        S_PLAY: rgb_d = {game_r, game_g, game_b};
`ifdef END_SCREEN_FADE_EN
        S_FADE: rgb_d = {scale(game_r, level_q), scale(game_g, level_q), scale(game_b, level_q)};
`endif
        S_SHOW, S_HOLD: if (in_win_q) rgb_d = {ov_r, ov_g, ov_b};
        default: rgb_d = 12'h000;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_PLAY;
      hold_cnt_q   <= '0;
      pend_lose_q  <= 1'b0;
      pend_win_q   <= 1'b0;
      img_sel_q    <= 1'b0;
      game_reset_q <= 1'b0;
      in_win_q     <= 1'b0;
      rgb_q        <= 12'h000;
`ifdef END_SCREEN_FADE_EN
      level_q      <= 5'd16;
      fade_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      pend_lose_q  <= pend_lose_d;
      pend_win_q   <= pend_win_d;
      img_sel_q    <= img_sel_d;
      game_reset_q <= game_reset_d;
      in_win_q     <= in_win;
      rgb_q        <= rgb_d;
`ifdef END_SCREEN_FADE_EN
      level_q      <= level_d;
      fade_cnt_q   <= fade_cnt_d;
`endif
    end
  end

  assign img_sel    = img_sel_q;
  assign game_reset = game_reset_q;
  assign end_screen = (state_q != S_PLAY);
  assign dbg_state  = state_q;
  assign red        = rgb_q[11:8];
  assign green      = rgb_q[7:4];
  assign blue       = rgb_q[3:0];

endmodule

// File: tb/tb_end_screen_sequencer.sv
// Bench for end_screen_sequencer: random raster/event stimulus, frame-level reference model,
// expected-output queue drained by a monitor once per clock.
module tb_end_screen_sequencer;

  localparam int IMG_W       = 320;
  localparam int IMG_H       = 240;
  localparam int IMG_X0      = 160;
  localparam int IMG_Y0      = 120;
  localparam int FADE_STEP   = 2;
  localparam int HOLD_FRAMES = 60;
`ifdef END_SCREEN_FADE_EN
  localparam bit FADE_ON = 1'b1;
`else
  localparam bit FADE_ON = 1'b0;
`endif

  localparam int M_PLAY = 0;
  localparam int M_FADE = 1;
  localparam int M_SHOW = 2;
  localparam int M_HOLD = 3;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        go;
    logic        gw;
    logic        st;
    logic [11:0] game;
    logic [11:0] ov;
  } stim_t;

  // ---------------- clock / reset ----------------
  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, game_over, game_won, start;
  logic [3:0]  game_r, game_g, game_b, ov_r, ov_g, ov_b;
  logic [16:0] img_addr;
  logic        img_sel, end_screen, game_reset;
  logic [3:0]  red, green, blue;
  logic [1:0]  dbg_state;

  always #5 vga_clk = ~vga_clk;

  end_screen_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0),
    .FADE_STEP(FADE_STEP), .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .game_over(game_over), .game_won(game_won), .start(start),
    .game_r(game_r), .game_g(game_g), .game_b(game_b),
    .ov_r(ov_r), .ov_g(ov_g), .ov_b(ov_b),
    .img_addr(img_addr), .img_sel(img_sel), .end_screen(end_screen),
    .game_reset(game_reset), .red(red), .green(green), .blue(blue),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  bit          mon_en = 1'b0;
  int          n_vectors = 0;
  int          n_miscompares = 0;

  // Reference model: game phase plus tick counts since the phase began.
  int m_mode;
  bit m_lose, m_win, m_sel, m_inwin_prev;
  int m_fade_ticks, m_show_ticks;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vectors++;
    if (act != exp) begin
      n_miscompares++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic flag_timeout(input string name);
    n_vectors++;
    n_miscompares++;
    $display("FAIL %s @%0t: bound expired before the model reached the expected phase", name, $time);
  endtask

  function automatic void model_reset();
    m_mode       = M_PLAY;
    m_lose       = 1'b0;
    m_win        = 1'b0;
    m_sel        = 1'b0;
    m_inwin_prev = 1'b0;
    m_fade_ticks = 0;
    m_show_ticks = 0;
  endfunction

  function automatic int model_level();
    int lv;
    lv = 16 - (m_fade_ticks + FADE_STEP - 1) / FADE_STEP;
    return (lv < 0) ? 0 : lv;
  endfunction

  task automatic model_step(input stim_t s);
    bit          tick, inwin, greset, es;
    int          addr, lv, xi, yi;
    logic [11:0] px;
    xi    = int'(s.x);
    yi    = int'(s.y);
    tick  = (xi == 0) && (yi == 0);
    inwin = (xi >= IMG_X0) && (xi < IMG_X0 + IMG_W) && (yi >= IMG_Y0) && (yi < IMG_Y0 + IMG_H);
    addr  = inwin ? ((xi - IMG_X0) + (yi - IMG_Y0) * IMG_W) % 131072 : 0;
    if (!s.blank)               px = 12'h000;
    else if (m_mode == M_PLAY)  px = s.game;
    else if (m_mode == M_FADE) begin
      lv = model_level();
      px = {4'((int'(s.game[11:8]) * lv) / 16), 4'((int'(s.game[7:4]) * lv) / 16),
            4'((int'(s.game[3:0]) * lv) / 16)};
    end else                    px = m_inwin_prev ? s.ov : 12'h000;
    greset = (m_mode == M_HOLD) && s.st;
    case (m_mode)
      M_PLAY: begin
        if (tick && (m_lose || m_win)) begin
          m_sel        = m_win && !m_lose;
          m_lose       = 1'b0;
          m_win        = 1'b0;
          m_fade_ticks = 0;
          m_show_ticks = 0;
          m_mode       = FADE_ON ? M_FADE : M_SHOW;
        end else begin
          m_lose = m_lose || s.go;
          m_win  = m_win || s.gw;
        end
      end
      M_FADE: if (tick) begin
        if (model_level() == 0) begin
          m_mode       = M_SHOW;
          m_show_ticks = 0;
        end else m_fade_ticks++;
      end
      M_SHOW: if (tick) begin
        m_show_ticks++;
        if (m_show_ticks == HOLD_FRAMES) m_mode = M_HOLD;
      end
      default: if (s.st) m_mode = M_PLAY;
    endcase
    m_inwin_prev = inwin;
    es = (m_mode != M_PLAY);
    exp_q.push_back({px, greset, es, m_sel, 17'(addr)});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input stim_t s);
    @(negedge vga_clk);
    DrawX     = s.x;
    DrawY     = s.y;
    blank     = s.blank;
    game_over = s.go;
    game_won  = s.gw;
    start     = s.st;
    {game_r, game_g, game_b} = s.game;
    {ov_r, ov_g, ov_b}       = s.ov;
    mon_en = 1'b1;
    model_step(s);
  endtask

  function automatic stim_t rand_stim(input bit tick, input int ev_pct, input int st_pct, input bit fixed);
    stim_t s;
    int bx[6];
    int by[6];
    bx = '{159, 160, 161, 478, 479, 480};
    by = '{119, 120, 121, 358, 359, 360};
    if ($urandom_range(0, 3) == 0) begin
      s.x = 10'(bx[$urandom_range(0, 5)]);
      s.y = 10'(by[$urandom_range(0, 5)]);
    end else begin
      s.x = 10'($urandom_range(0, 639));
      s.y = 10'($urandom_range(0, 479));
    end
    if (tick) begin
      s.x = 10'd0;
      s.y = 10'd0;
    end else if (s.x == 10'd0 && s.y == 10'd0) s.x = 10'd1;
    s.blank = fixed ? 1'b1 : ($urandom_range(0, 7) != 0);
    s.go    = (int'($urandom_range(0, 99)) < ev_pct);
    s.gw    = (int'($urandom_range(0, 99)) < ev_pct);
    s.st    = (int'($urandom_range(0, 99)) < st_pct);
    s.game  = fixed ? 12'hFFF : 12'($urandom);
    s.ov    = 12'($urandom);
    return s;
  endfunction

  task automatic run_frames(input int n, input int ev_pct, input int st_pct, input bit fixed);
    for (int f = 0; f < n; f++) begin
      drive(rand_stim(1'b1, ev_pct, st_pct, fixed));
      for (int c = 0; c < int'($urandom_range(3, 8)); c++)
        drive(rand_stim(1'b0, ev_pct, st_pct, fixed));
    end
  endtask

  task automatic idle_inputs();
    DrawX = 10'd5; DrawY = 10'd5; blank = 1'b1;
    game_over = 1'b0; game_won = 1'b0; start = 1'b0;
    {game_r, game_g, game_b} = 12'h123;
    {ov_r, ov_g, ov_b}       = 12'h456;
  endtask

  task automatic probe_window();
    stim_t s;
    int px[5];
    int py[5];
    px = '{160, 479, 159, 480, 160};
    py = '{120, 359, 120, 359, 119};
    for (int i = 0; i < 5; i++) begin
      s = rand_stim(1'b0, 0, 0, 1'b0);
      s.x = 10'(px[i]);
      s.y = 10'(py[i]);
      s.blank = 1'b1;
      drive(s);
      drive(s);
    end
  endtask

  task automatic play_game(input int kind, input bit fixed, input bit probe);
    stim_t s;
    int    guard;
    run_frames(2, 0, 20, fixed);
    s = rand_stim(1'b0, 0, 0, fixed);
    case (kind)
      0:       begin s.go = 1'b1; s.gw = 1'b0; end
      1:       begin s.go = 1'b1; s.gw = 1'b1; end
      2:       begin s.go = 1'b0; s.gw = 1'b1; end
      default: begin s.go = 1'($urandom_range(0, 1)); s.gw = !s.go || 1'($urandom_range(0, 1)); end
    endcase
    drive(s);
    for (int c = 0; c < int'($urandom_range(0, 4)); c++) drive(rand_stim(1'b0, 0, 0, fixed));
    guard = 0;
    while (m_mode != M_SHOW && guard < 80) begin
      run_frames(1, 5, 15, fixed);
      guard++;
    end
    if (guard >= 80) flag_timeout("reach_show");
    if (probe) probe_window();
    guard = 0;
    while (m_mode != M_PLAY && guard < 200) begin
      run_frames(1, 5, 3, 1'b0);
      guard++;
    end
    if (guard >= 200) flag_timeout("reach_play");
  endtask

  task automatic async_reset_check();
    @(negedge vga_clk);
    mon_en = 1'b0;
    exp_q.delete();
    #2 reset_n = 1'b0;
    #1;
    check("async_rgb", {red, green, blue}, 12'h000);
    check("async_end_screen", end_screen, 0);
    check("async_game_reset", game_reset, 0);
    check("async_img_sel", img_sel, 0);
    idle_inputs();
    repeat (2) @(negedge vga_clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  always begin
    @(posedge vga_clk);
    #2;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_vectors++;
        n_miscompares++;
        $display("FAIL exp_underflow @%0t: got an output cycle, want a queued expectation", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rgb", {red, green, blue}, mon_e[31:20]);
        check("game_reset", game_reset, mon_e[19]);
        check("end_screen", end_screen, mon_e[18]);
        check("img_sel", img_sel, mon_e[17]);
        check("img_addr", img_addr, mon_e[16:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog @%0t: got no completion, want end of stimulus", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    stim_t s;
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge vga_clk);
    check("reset_rgb", {red, green, blue}, 12'h000);
    check("reset_end_screen", end_screen, 0);
    check("reset_game_reset", game_reset, 0);
    check("reset_img_sel", img_sel, 0);
    #1 reset_n = 1'b1;

    // Mid-frame release, one tick, then a fixed game colour with blank toggling.
    for (int i = 0; i < 3; i++) drive(rand_stim(1'b0, 0, 0, 1'b0));
    drive(rand_stim(1'b1, 0, 0, 1'b0));
    for (int i = 0; i < 6; i++) begin
      s = rand_stim(1'b0, 0, 0, 1'b0);
      s.game  = 12'hA5F;
      s.blank = i[0];
      drive(s);
    end

    play_game(0, 1'b1, 1'b1);
    play_game(1, 1'b0, 1'b0);
    play_game(2, 1'b0, 1'b1);
    play_game(3, 1'b0, 1'b0);
    play_game(3, 1'b0, 1'b0);

    // Reset while the end sequence is running, then a full game from full brightness.
    run_frames(1, 0, 0, 1'b1);
    s = rand_stim(1'b0, 0, 0, 1'b1);
    s.go = 1'b1;
    drive(s);
    run_frames(6, 0, 0, 1'b1);
    async_reset_check();
    play_game(0, 1'b1, 1'b0);
    run_frames(2, 0, 0, 1'b0);

    @(posedge vga_clk);
    #4;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
